// File: rtl/tohost_pkg.sv
// Shared definitions for the tohost end-of-test monitor.
//  - state_t          : monitor FSM encoding (RUN, DONE, TIMEOUT)
//  - DEF_TOHOST_ADDR  : default word address of the tohost register
//  - DEF_CONSOLE_ADDR : default word address of the console byte register
//  - FAIL_PROTO       : fail_id reported for a tohost syscall / protocol error
//  - word_match       : compares two byte addresses at word granularity
package tohost_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1000;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_1004;
  localparam logic [30:0] FAIL_PROTO       = 31'h7FFF_FFFF;

  // Word-granular address compare; callers pass addr[31:2].
  function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/cons_fifo.sv
// Synchronous FIFO buffering console bytes.
// Ports:
//  clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//  push       : write push_data this cycle (accepted when not full, or when
//               full and a pop happens in the same cycle)
//  push_data  : byte to write
//  pop        : remove head entry this cycle (ignored when empty)
//  pop_data   : head entry (valid when !empty, stable until popped)
//  full/empty : occupancy flags
module cons_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  // One extra bit so a full FIFO is distinguishable from an empty one.
  logic [AW:0]      count;

  logic do_pop;
  logic do_push;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count define which
  // entries are meaningful, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tohost_monitor.sv
// End-of-test responder for riscv-tests runs. Snoops the core store port,
// decodes the tohost protocol, buffers console bytes and runs a watchdog.
// Ports:
//  clk, rst       : clock, synchronous active-high reset (wins over stores)
//  wr_en/wr_addr/wr_data/wr_strb : core store port (address compared on [31:2])
//  done           : sticky, test finished (pass, fail or timeout)
//  pass           : sticky, tohost==1 received
//  fail_id        : failing test number, all-ones for a protocol error
//  timeout        : sticky, watchdog fired
//  cycles         : cycles spent in RUN, frozen once finished
//  cons_valid/cons_data/cons_ready : console byte stream (drains after done)
//  cons_overflow  : sticky, a console byte was dropped on a full FIFO
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR   = DEF_TOHOST_ADDR,
  parameter logic [31:0] CONSOLE_ADDR  = DEF_CONSOLE_ADDR,
  parameter int          TIMEOUT_TICKS = 5000,
  parameter int          CNT_W         = 16,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             done,
  output logic             pass,
  output logic [30:0]      fail_id,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic             cons_valid,
  output logic [7:0]       cons_data,
  input  logic             cons_ready,
  output logic             cons_overflow
);

  state_t state;
  state_t state_next;

  logic tohost_hit;
  logic tohost_final;
  logic expire;
  logic cons_push;
  logic cons_pop;
  logic cons_full;
  logic cons_empty;

  // Byte-lane bits of the store address play no part in word decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^wr_addr[1:0];

  // Only full-word stores while running count as tohost writes.
  assign tohost_hit = wr_en && (state == ST_RUN) && (wr_strb == 4'hF)
                   && word_match(wr_addr[31:2], TOHOST_ADDR[31:2]);
  // A zero write is the idle value of tohost and does not end the test.
  assign tohost_final = tohost_hit && (wr_data != 32'h0);
  assign expire       = (state == ST_RUN) && (cycles == CNT_W'(TIMEOUT_TICKS - 1));

  assign cons_push = wr_en && (state == ST_RUN) && wr_strb[0]
                  && word_match(wr_addr[31:2], CONSOLE_ADDR[31:2]);
  assign cons_pop  = cons_valid && cons_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // NOTE: next state is defaulted before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      // A tohost result on the expiry cycle takes priority over the watchdog.
      ST_RUN:     if (tohost_final) state_next = ST_DONE;
                  else if (expire)  state_next = ST_TIMEOUT;
      ST_DONE:    state_next = ST_DONE;
      ST_TIMEOUT: state_next = ST_TIMEOUT;
      default:    state_next = ST_RUN;
    endcase
  end

  assign done    = (state != ST_RUN);
  assign timeout = (state == ST_TIMEOUT);

  // ------------------------------------------------ result flags/counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pass    <= 1'b0;
      fail_id <= '0;
    end else if (tohost_final) begin
      pass <= (wr_data == 32'h1);
      if (!wr_data[0])             fail_id <= FAIL_PROTO;   // syscall request
      else if (wr_data == 32'h1)   fail_id <= '0;
      else                         fail_id <= wr_data[31:1];
    end
  end

  // Counts only cycles that remain in RUN, so the finishing cycle's value holds.
  always_ff @(posedge clk) begin
    if (rst)                         cycles <= '0;
    else if (state_next == ST_RUN)   cycles <= cycles + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                      cons_overflow <= 1'b0;
    else if (cons_push && cons_full && !cons_pop) cons_overflow <= 1'b1;
  end

  // ------------------------------------------------------------ console
  cons_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_cons_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cons_push),
    .push_data (wr_data[7:0]),
    .pop       (cons_pop),
    .pop_data  (cons_data),
    .full      (cons_full),
    .empty     (cons_empty)
  );

  assign cons_valid = !cons_empty;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: tohost decode, watchdog, console FIFO
// ordering/overflow and mid-run reset. Console bytes go through a queue
// scoreboard; inputs change and outputs are sampled on the falling edge.
module tb_tohost_monitor;
  import tohost_pkg::*;

  localparam int          TICKS   = 100;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] A_HOST  = 32'h0000_1000;
  localparam logic [31:0] A_CONS  = 32'h0000_1004;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        done;
  logic        pass;
  logic [30:0] fail_id;
  logic        timeout;
  logic [15:0] cycles;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        cons_overflow;

  tohost_monitor #(
    .TOHOST_ADDR   (A_HOST),
    .CONSOLE_ADDR  (A_CONS),
    .TIMEOUT_TICKS (TICKS),
    .CNT_W         (16),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .done          (done),
    .pass          (pass),
    .fail_id       (fail_id),
    .timeout       (timeout),
    .cycles        (cycles),
    .cons_valid    (cons_valid),
    .cons_data     (cons_data),
    .cons_ready    (cons_ready),
    .cons_overflow (cons_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb [$];
  int         model_count;
  logic       exp_ovf;
  logic [7:0] b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Leaves the bench on the falling edge of cycle 0 (cycles==0, reset released).
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; cons_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_count = 0;
    exp_ovf = 1'b0;
  endtask

  // One-cycle store; returns on the next falling edge with wr_en low.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Console push with no concurrent pop: model accepts while below DEPTH.
  task automatic cons_write(input logic [7:0] val);
    if (model_count < DEPTH) begin
      sb.push_back(val);
      model_count++;
    end else begin
      exp_ovf = 1'b1;
    end
    store(A_CONS, {24'h0, val}, 4'h1);
  endtask

  task automatic drain(input string tag);
    cons_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cons_valid) begin
        if (sb.size() == 0) check({tag, "_unexpected_byte"}, 32'(cons_valid), 32'h0);
        else                check(tag, 32'(cons_data), 32'(sb.pop_front()));
      end else if (sb.size() == 0) begin
        break;
      end
      @(negedge clk);
    end
    check({tag, "_left_in_scoreboard"}, 32'(sb.size()), 32'h0);
    cons_ready = 1'b0;
    model_count = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_guard: bench did not finish in time");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; cons_ready = 1'b0;

    // ---- reset state, then pass at cycle 40
    do_reset();
    check("rst_done",     32'(done), 32'h0);
    check("rst_pass",     32'(pass), 32'h0);
    check("rst_fail_id",  32'(fail_id), 32'h0);
    check("rst_timeout",  32'(timeout), 32'h0);
    check("rst_cycles",   32'(cycles), 32'h0);
    check("rst_cvalid",   32'(cons_valid), 32'h0);
    check("rst_overflow", 32'(cons_overflow), 32'h0);
    repeat (40) @(negedge clk);
    check("t1_cycles_pre", 32'(cycles), 32'd40);
    store(A_HOST, 32'h1, 4'hF);
    check("t1_done",    32'(done), 32'h1);
    check("t1_pass",    32'(pass), 32'h1);
    check("t1_fail_id", 32'(fail_id), 32'h0);
    check("t1_timeout", 32'(timeout), 32'h0);
    check("t1_cycles",  32'(cycles), 32'd40);
    repeat (3) @(negedge clk);
    check("t1_cycles_frozen", 32'(cycles), 32'd40);
    store(A_CONS, 32'h58, 4'h1);
    @(negedge clk);
    check("t1_cons_ignored_after_done", 32'(cons_valid), 32'h0);

    // ---- one-cycle reset after pass clears everything
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_done",     32'(done), 32'h0);
    check("t6_pass",     32'(pass), 32'h0);
    check("t6_fail_id",  32'(fail_id), 32'h0);
    check("t6_timeout",  32'(timeout), 32'h0);
    check("t6_cycles",   32'(cycles), 32'h0);
    check("t6_cvalid",   32'(cons_valid), 32'h0);
    check("t6_overflow", 32'(cons_overflow), 32'h0);
    store(A_HOST, 32'h1, 4'hF);
    check("t6_repass_done", 32'(done), 32'h1);
    check("t6_repass_pass", 32'(pass), 32'h1);

    // ---- fail with test number 3, later pass store ignored
    do_reset();
    store(A_HOST, 32'h7, 4'hF);
    check("t2_done",    32'(done), 32'h1);
    check("t2_pass",    32'(pass), 32'h0);
    check("t2_fail_id", 32'(fail_id), 32'd3);
    store(A_HOST, 32'h1, 4'hF);
    check("t2_sticky_pass",    32'(pass), 32'h0);
    check("t2_sticky_fail_id", 32'(fail_id), 32'd3);

    // ---- ignored stores, then syscall/protocol error
    do_reset();
    store(A_HOST, 32'h0, 4'hF);
    check("t4_zero_ignored", 32'(done), 32'h0);
    store(32'h0000_2000, 32'h1, 4'hF);
    check("t4_other_addr_ignored", 32'(done), 32'h0);
    store(A_HOST, 32'h1, 4'h3);
    check("t4_partial_done", 32'(done), 32'h0);
    check("t4_partial_pass", 32'(pass), 32'h0);
    store(A_HOST, 32'h4, 4'hF);
    check("t4_proto_done",    32'(done), 32'h1);
    check("t4_proto_pass",    32'(pass), 32'h0);
    check("t4_proto_fail_id", 32'(fail_id), 32'h7FFF_FFFF);

    // ---- watchdog
    do_reset();
    repeat (TICKS - 1) @(negedge clk);
    check("t3_cycles_last",  32'(cycles), 32'(TICKS - 1));
    check("t3_not_yet",      32'(timeout), 32'h0);
    @(negedge clk);
    check("t3_timeout", 32'(timeout), 32'h1);
    check("t3_done",    32'(done), 32'h1);
    check("t3_pass",    32'(pass), 32'h0);
    check("t3_fail_id", 32'(fail_id), 32'h0);
    store(A_HOST, 32'h1, 4'hF);
    check("t3_store_after_timeout", 32'(pass), 32'h0);
    // tohost store on the expiry cycle wins
    do_reset();
    repeat (TICKS - 1) @(negedge clk);
    store(A_HOST, 32'h1, 4'hF);
    check("t3b_timeout", 32'(timeout), 32'h0);
    check("t3b_pass",    32'(pass), 32'h1);
    check("t3b_done",    32'(done), 32'h1);

    // ---- console: overflow with 9 pushes into depth 8, in-order drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = 8'h41 + 8'(i);
      cons_write(b);
      if (i == 0) check("t5_valid_next_cycle", 32'(cons_valid), 32'h1);
    end
    check("t5_overflow", 32'(cons_overflow), 32'(exp_ovf));
    check("t5_head", 32'(cons_data), 32'h41);
    repeat (3) @(negedge clk);
    check("t5_head_stable", 32'(cons_data), 32'h41);
    drain("t5_drain");

    // ---- console: push while full with simultaneous pop is not dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'h61 + 8'(i);
      cons_write(b);
    end
    check("t5b_full_no_overflow", 32'(cons_overflow), 32'h0);
    cons_ready = 1'b1;
    check("t5b_pop_head", 32'(cons_data), 32'(sb.pop_front()));
    sb.push_back(8'h7A);
    store(A_CONS, 32'h7A, 4'h1);
    check("t5b_overflow_after_push_pop", 32'(cons_overflow), 32'h0);
    drain("t5b_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
